// File: rtl/bounce_generator.sv
// ---------------------------------------------------------------------------
// bounce_generator
//   Emulates a mechanical contact for exercising a debouncer. When the
//   requested level i_level differs from the emitted contact o_bouncy, the
//   block produces a burst of 2N+1 toggles. N is drawn from a free-running
//   LFSR and capped at p_BOUNCE_MAX. The burst ends on the requested level.
//   Each intermediate pulse is shorter than the debouncer tolerance of
//   2^p_CNT_WIDTH cycles. The final level is then held for 2^p_CNT_WIDTH+1
//   cycles, so a matched debouncer is guaranteed to accept it.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_level  : clean requested level
//   o_bouncy : emulated contact signal with bounce (registered)
//   o_busy   : high while a burst or its settle period is in progress
//   o_done   : one-cycle pulse when a transition has fully settled
// ---------------------------------------------------------------------------
module bounce_generator #(
    parameter int          p_CNT_WIDTH  = 2,
    parameter int          p_BOUNCE_MAX = 6,
    parameter logic [15:0] p_SEED       = 16'hACE1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_bouncy,
    output logic o_busy,
    output logic o_done
);

    // An all-zero state would lock up the LFSR.
    localparam logic [15:0] lp_SEED = (p_SEED == 16'h0000) ? 16'h0001 : p_SEED;
    localparam logic [15:0] lp_TAPS = 16'hB400;
    localparam logic [2:0]  lp_BMAX = 3'(p_BOUNCE_MAX);

    // Largest dwell reload value is 2^W-3, which gives D = 2^W-2 cycles.
    localparam logic [p_CNT_WIDTH-1:0] lp_ONES      = '1;
    localparam logic [p_CNT_WIDTH-1:0] lp_DWELL_MAX = lp_ONES - p_CNT_WIDTH'(2);

    // Counting down from 2^W to 0 holds the final level for 2^W+1 cycles.
    localparam logic [p_CNT_WIDTH:0]   lp_SETTLE    = {1'b1, {p_CNT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_SETTLE
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_lfsr;
    logic                   r_target;
    logic [3:0]             r_left;    // toggles still to come in BOUNCE (2N at start)
    logic [p_CNT_WIDTH-1:0] r_dwell;   // D-1 down to 0; reloaded before it can wrap
    logic [p_CNT_WIDTH:0]   r_settle;

    logic [15:0]            w_lfsr_next;
    logic [2:0]             w_n;
    logic [p_CNT_WIDTH-1:0] w_dwell_load;

    // Galois form: shift right and fold the tap mask in when bit 0 falls out.
    assign w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? lp_TAPS : 16'h0000);
    assign w_n          = (r_lfsr[2:0] > lp_BMAX) ? lp_BMAX : r_lfsr[2:0];
    assign w_dwell_load = (r_lfsr[p_CNT_WIDTH-1:0] > lp_DWELL_MAX) ?
                          lp_DWELL_MAX : r_lfsr[p_CNT_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_lfsr   <= lp_SEED;
            r_target <= 1'b0;
            r_left   <= '0;
            r_dwell  <= '0;
            r_settle <= '0;
            o_bouncy <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_level != o_bouncy) begin
                        r_target <= i_level;
                        o_bouncy <= ~o_bouncy;
                        o_busy   <= 1'b1;
                        if (w_n == 3'd0) begin
                            // A single clean edge skips straight to settling.
                            r_state  <= ST_SETTLE;
                            r_settle <= lp_SETTLE;
                        end else begin
                            r_state <= ST_BOUNCE;
                            r_left  <= {w_n, 1'b0};
                            r_dwell <= w_dwell_load;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (r_dwell != '0) begin
                        r_dwell <= r_dwell - 1'b1;
                    end else if (r_left == 4'd1) begin
                        // The final toggle always lands on the latched target.
                        o_bouncy <= r_target;
                        r_state  <= ST_SETTLE;
                        r_settle <= lp_SETTLE;
                    end else begin
                        o_bouncy <= ~o_bouncy;
                        r_left   <= r_left - 4'd1;
                        r_dwell  <= w_dwell_load;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_generator.sv
// ---------------------------------------------------------------------------
// tb_bounce_generator
//   Self-checking bench for bounce_generator.
//   u_dut uses the default parameters and gets randomized level changes and
//   reset pulses. It is compared cycle by cycle against a schedule model:
//   each burst is expanded into a queue of expected per-cycle outputs,
//   worked out from the LFSR sequence. A small debouncer with tolerance
//   2^W watches o_bouncy.
//   u_dut_nb uses p_BOUNCE_MAX=0 and is driven with a directed single-edge
//   test.
// ---------------------------------------------------------------------------
module tb_bounce_generator;

    localparam int          W    = 2;
    localparam int          BMAX = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    logic level;
    logic level2;
    logic bouncy, busy, done;
    logic b2, busy2, done2;

    always #5 clk = ~clk;

    bounce_generator #(.p_CNT_WIDTH(W), .p_BOUNCE_MAX(BMAX), .p_SEED(SEED)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_level(level),
        .o_bouncy(bouncy), .o_busy(busy), .o_done(done)
    );

    bounce_generator #(.p_CNT_WIDTH(2), .p_BOUNCE_MAX(0), .p_SEED(SEED)) u_dut_nb (
        .i_clk(clk), .i_rst(rst), .i_level(level2),
        .o_bouncy(b2), .o_busy(busy2), .o_done(done2)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ----------------------------------------------------------------------
    // Reference model: a burst is expanded up front into the list of
    // expected outputs, one entry per clock edge starting at the start edge.
    // ----------------------------------------------------------------------
    typedef struct packed {
        logic b;
        logic busy;
        logic done;
    } exp_t;

    exp_t        sched[$];
    exp_t        e_now;
    logic [15:0] m_lfsr;

    task automatic plan_burst(input logic tgt, input logic [15:0] lfsr_now);
        logic [15:0] v;
        int          n;
        int          d;
        logic        val;
        v   = lfsr_now;
        n   = (int'(v[2:0]) > BMAX) ? BMAX : int'(v[2:0]);
        val = ~tgt;
        // 2n pulses, each lasting D cycles; D is drawn at that pulse's toggle edge.
        for (int k = 0; k < 2 * n; k++) begin
            val = ~val;
            d   = 1 + ((int'(v[W-1:0]) > (1 << W) - 3) ? (1 << W) - 3 : int'(v[W-1:0]));
            for (int j = 0; j < d; j++) begin
                sched.push_back('{b: val, busy: 1'b1, done: 1'b0});
                v = lfsr_step(v);
            end
        end
        // Final edge to the target level, held for 2^W+1 cycles, then done.
        for (int j = 0; j < (1 << W) + 1; j++)
            sched.push_back('{b: tgt, busy: 1'b1, done: 1'b0});
        sched.push_back('{b: tgt, busy: 1'b0, done: 1'b1});
    endtask

    // Debouncer observer (tolerance 2^W cycles)
    logic deb_in   = 1'b0;
    logic deb_out  = 1'b0;
    int   deb_cnt  = 0;
    int   deb_chg  = 0;
    logic busy_prv = 1'b0;

    always begin
        @(posedge clk);
        if (rst) begin
            m_lfsr = SEED;
            sched.delete();
            e_now  = '0;
        end else begin
            if (sched.size() == 0 && level != e_now.b)
                plan_burst(level, m_lfsr);
            if (sched.size() != 0)
                e_now = sched.pop_front();
            else
                e_now = '{b: e_now.b, busy: 1'b0, done: 1'b0};
            m_lfsr = lfsr_step(m_lfsr);
        end
        #1;
        check_val("bouncy", bouncy, e_now.b);
        check_val("busy",   busy,   e_now.busy);
        check_val("done",   done,   e_now.done);

        if (busy && !busy_prv) deb_chg = 0;
        if (bouncy !== deb_in) begin
            deb_in  = bouncy;
            deb_cnt = 0;
        end else if (deb_cnt < 1000) begin
            deb_cnt++;
        end
        if (deb_cnt >= (1 << W) && deb_out != deb_in) begin
            deb_out = deb_in;
            deb_chg++;
        end
        if (done) begin
            check_val("pair_level", deb_out, e_now.b);
            check_val("pair_once", (deb_chg <= 1) ? 1 : 0, 1);
        end
        busy_prv = busy;
    end

    int rst_hold = 0;

    initial begin
        rst    = 1'b1;
        level  = 1'b1;
        level2 = 1'b0;

        // Reset held for three edges with the level requesting 1
        repeat (3) begin
            @(posedge clk); #1;
            check_val("rst_bouncy", bouncy, 0);
            check_val("rst_busy",   busy,   0);
            check_val("rst_done",   done,   0);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_release_edge", bouncy, 1);
        check_val("rst_release_busy", busy,   1);
        check_val("nb_idle", b2, 0);

        // p_BOUNCE_MAX=0: one edge one cycle later, busy for 5 cycles, then done
        @(negedge clk) level2 = 1'b1;
        @(posedge clk); #1;
        check_val("nb_edge",      b2,    1);
        check_val("nb_busy_rise", busy2, 1);
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            check_val("nb_hold",      b2,    1);
            check_val("nb_busy_hold", busy2, 1);
            check_val("nb_no_done",   done2, 0);
        end
        @(posedge clk); #1;
        check_val("nb_done",      done2, 1);
        check_val("nb_busy_fall", busy2, 0);
        @(posedge clk); #1;
        check_val("nb_done_pulse", done2, 0);
        check_val("nb_final",      b2,    1);

        // Ignore-while-busy: a double toggle during the burst gives no new burst
        begin
            int t = 0;
            while (busy !== 1'b0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check_val("idle_wait_timeout", (t < 100) ? 1 : 0, 1);
        end
        @(negedge clk) level = ~level;
        repeat (2) @(negedge clk);
        level = ~level;
        @(negedge clk) level = ~level;
        @(negedge clk) level = ~level;
        repeat (40) @(negedge clk);

        // Randomized level changes with occasional short resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) level = ~level;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst      = 1'b1;
                rst_hold = $urandom_range(1, 3);
            end
        end
        @(negedge clk) rst = 1'b0;

        // Reset in the middle of a burst, then a fresh burst from the seed
        @(negedge clk) level = ~bouncy;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_bouncy", bouncy, 0);
        check_val("midrst_busy",   busy,   0);
        @(negedge clk) begin
            rst   = 1'b0;
            level = 1'b1;
        end
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
